// File: rtl/seg7_mux_driver_pkg.sv
// Shared types and constants for the two-digit 7-segment mux driver.
// Holds the FSM state enum, the hex decode table and the blank pattern.
package seg7_mux_driver_pkg;

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high gfedcba, index 0 is the rightmost entry.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_mux_driver_hex_to_seg.sv
// Combinational hex digit to active-high gfedcba segment decoder.
// Ports: hex_i (4-bit digit), seg_o (7-bit segments, a = LSB).
module hex_to_seg
  import seg7_mux_driver_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seg7_mux_driver.sv
// Two-digit multiplexed 7-segment driver with blanking and frame-safe update.
// Ports: clk, rst, value_in/valid/ready handshake, seg_n, dig_sel, frame_tick.
module seg7_mux_driver
  import seg7_mux_driver_pkg::*;
#(
  parameter int REFRESH_DIV  = 12000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value_in,
  input  logic       value_valid,
  output logic       value_ready,
  output logic [6:0] seg_n,
  output logic       dig_sel,
  output logic       frame_tick
);

  localparam int MAXD =
    (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW = $clog2(MAXD);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] lim;
  logic [7:0]    disp_q, shadow_q;
  logic          pending_q;
  logic [6:0]    seg_q;
  logic          dig_q, tick_q;

  logic       show;
  logic       done;
  logic       commit;
  logic       xfer;
  logic [3:0] hex;
  logic [6:0] dec;

  assign show = (state_q == SHOW0) || (state_q == SHOW1);
  assign lim  = show ? CW'(REFRESH_DIV - 1)
                     : CW'(BLANK_CYCLES - 1);
  assign done = (cnt_q == lim);

  // Display only updates at the frame boundary.
  assign commit = done && (state_q == BLANK1);
  assign xfer   = value_valid && !pending_q;

  assign value_ready = !pending_q;

  assign hex = (state_q == SHOW1) ? disp_q[7:4]
                                  : disp_q[3:0];

  hex_to_seg u_dec (
    .hex_i (hex),
    .seg_o (dec)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    if (done) begin
      cnt_d = '0;
      unique case (state_q)
        SHOW0:   state_d = BLANK0;
        BLANK0:  state_d = SHOW1;
        SHOW1:   state_d = BLANK1;
        BLANK1:  state_d = SHOW0;
        default: state_d = BLANK1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BLANK1;
      cnt_q     <= '0;
      disp_q    <= 8'h00;
      shadow_q  <= 8'h00;
      pending_q <= 1'b0;
      seg_q     <= SEG_OFF;
      dig_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit && pending_q) begin
        disp_q    <= shadow_q;
        pending_q <= 1'b0;
      end else if (xfer) begin
        shadow_q  <= value_in;
        pending_q <= 1'b1;
      end
      // Outputs trail the state by one cycle.
      seg_q  <= show ? ~dec : SEG_OFF;
      dig_q  <= (state_q == BLANK0) || (state_q == SHOW1);
      tick_q <= (state_q == SHOW0) && (cnt_q == '0);
    end
  end

  assign seg_n      = seg_q;
  assign dig_sel    = dig_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Self-checking bench for seg7_mux_driver with an abstract timing model.
// Model derives outputs from cycle position in the frame via modular math.
module tb_seg7_mux_driver;

  localparam int R = 4;
  localparam int B = 2;
  localparam int P = 2 * (R + B);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value_in = 8'h00;
  logic       value_valid = 1'b0;
  logic       value_ready;
  logic [6:0] seg_n;
  logic       dig_sel;
  logic       frame_tick;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg7_mux_driver #(
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .seg_n       (seg_n),
    .dig_sel     (dig_sel),
    .frame_tick  (frame_tick)
  );

  function automatic logic [6:0] dec(input logic [3:0] h);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[h];
  endfunction

  // 0 SHOW0, 1 BLANK0, 2 SHOW1, 3 BLANK1 for cycle j after reset.
  function automatic int phase(input int j);
    int q;
    if (j < B) return 3;
    q = (j - B) % P;
    if (q < R) return 0;
    if (q < R + B) return 1;
    if (q < 2 * R + B) return 2;
    return 3;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model state
  int         m = 0;
  logic [7:0] md = 8'h00;
  logic [7:0] ms = 8'h00;
  bit         mp = 1'b0;
  bit         started = 1'b0;
  logic [6:0] es;
  logic       ed, et;
  int         ph;
  logic       prev_dig = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      m  = 0;
      md = 8'h00;
      ms = 8'h00;
      mp = 1'b0;
      es = 7'h7F;
      ed = 1'b0;
      et = 1'b0;
    end else if (started) begin
      ph = phase(m);
      es = (ph == 0) ? ~dec(md[3:0]) :
           (ph == 2) ? ~dec(md[7:4]) : 7'h7F;
      ed = (ph == 1) || (ph == 2);
      et = (m >= B) && ((m - B) % P == 0);
      m++;
      if ((m >= B) && ((m - B) % P == 0) && mp) begin
        md = ms;
        mp = 1'b0;
      end else if (value_valid && !mp) begin
        ms = value_in;
        mp = 1'b1;
      end
    end
    if (started) begin
      #1;
      chk("seg_n", seg_n, es);
      chk("dig_sel", dig_sel, ed);
      chk("frame_tick", frame_tick, et);
      chk("value_ready", value_ready, !mp);
      if (dig_sel !== prev_dig)
        chk("ghost", seg_n, 7'h7F);
      prev_dig = dig_sel;
    end
  end

  task automatic wait_m(input int k);
    int g = 0;
    while (m != k && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) chk("wait_m timeout", 1, 0);
  endtask

  task automatic wait_ph(input int p, input bit need_pend);
    int g = 0;
    while ((phase(m) != p || (need_pend && !mp)) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) chk("wait_ph timeout", 1, 0);
  endtask

  task automatic wait_tick();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!frame_tick && g < 100);
    if (g >= 100) chk("tick timeout", 1, 0);
  endtask

  task automatic send(input logic [7:0] v);
    int g = 0;
    value_in    = v;
    value_valid = 1'b1;
    while (!value_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk("send timeout", 1, 0);
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst ready", value_ready, 1'b1);
    chk("rst seg", seg_n, 7'h7F);
    rst = 1'b0;

    // Idle after reset: literal timing pins
    wait_m(1);
    chk("lit m1 seg", seg_n, 7'h7F);
    wait_m(3);
    chk("lit m3 seg", seg_n, 7'h40);
    chk("lit m3 tick", frame_tick, 1'b1);
    chk("lit m3 dig", dig_sel, 1'b0);
    wait_m(9);
    chk("lit m9 seg", seg_n, 7'h40);
    chk("lit m9 dig", dig_sel, 1'b1);
    wait_m(15);
    chk("lit m15 tick", frame_tick, 1'b1);

    // A5 mid-SHOW1
    wait_ph(2, 1'b0);
    @(negedge clk);
    value_in    = 8'hA5;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    chk("lit A5 ready low", value_ready, 1'b0);
    wait_tick();
    chk("lit A5 ones", seg_n, 7'h12);
    chk("lit A5 ready", value_ready, 1'b1);
    repeat (6) @(negedge clk);
    chk("lit A5 tens", seg_n, 7'h08);
    chk("lit A5 dig", dig_sel, 1'b1);

    // 12 then held 34
    send(8'h12);
    send(8'h34);
    repeat (2 * P) @(negedge clk);

    // Sweep all values, one per frame
    for (int v = 0; v < 256; v++) send(8'(v));
    repeat (2 * P) @(negedge clk);

    // Reset during SHOW1 with a pending value
    wait_tick();
    value_in    = 8'h9C;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    wait_ph(2, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("lit rst seg", seg_n, 7'h7F);
    chk("lit rst dig", dig_sel, 1'b0);
    chk("lit rst ready", value_ready, 1'b1);
    repeat (2 * P) @(negedge clk);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      value_valid = ($urandom % 4) == 0;
      value_in    = 8'($urandom);
      @(negedge clk);
    end
    value_valid = 1'b0;
    repeat (2 * P) @(negedge clk);

    // value_in churn with valid low
    for (int i = 0; i < 40; i++) begin
      value_in = 8'($urandom);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_mux_driver.md
SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 12000: clk cycles per digit SHOW phase (about 1 kHz per digit at 12 MHz); legal range >= 2.
REQ-002 SHALL have parameter BLANK_CYCLES, default 16: clk cycles per BLANK phase between digits; legal range >= 1.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock, sole clock domain.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 value_in  input  8  two hex digits: [3:0] is digit 0 (ones), [7:4] is digit 1.
REQ-007 value_valid  input  1  producer offers value_in.
REQ-008 value_ready  output  1  block can accept a value; transfer occurs when value_valid && value_ready.
REQ-009 seg_n  output  7  active-low segments, bit order {g,f,e,d,c,b,a} (a = LSB).
REQ-010 dig_sel  output  1  digit select: 0 = digit 0, 1 = digit 1.
REQ-011 frame_tick  output  1  one-cycle pulse on each entry to SHOW0.

Function
REQ-012 SHALL hold the display register disp[7:0], the shadow register shadow[7:0] and the flag pending.
REQ-013 value_ready SHALL equal !pending, driven combinationally from the register.
REQ-014 On a transfer, shadow SHALL load value_in and pending SHALL set on that clock edge; value_in is ignored whenever value_ready = 0.
REQ-015 The FSM SHALL have states SHOW0, BLANK0, SHOW1, BLANK1 and cycle through them in that order, repeating.
REQ-016 Each SHOW state SHALL last exactly REFRESH_DIV cycles and each BLANK state exactly BLANK_CYCLES cycles, timed by one phase counter cleared on every state change; frame period = 2*(REFRESH_DIV+BLANK_CYCLES).
REQ-017 On the BLANK1->SHOW0 transition, if pending = 1, disp SHALL load shadow and pending SHALL clear; value_ready rises on the next cycle.
REQ-018 disp SHALL change only on the BLANK1->SHOW0 transition, so no frame shows digits from two different values.
REQ-019 A value_valid that arrives while pending = 1 SHALL stall; shadow is never overwritten before commit.
REQ-020 Outputs SHALL be registered and SHALL reflect the current state, with one cycle of latency after each transition:
- SHOW0: seg_n = ~DEC(disp[3:0]), dig_sel = 0
- BLANK0: seg_n = 7'h7F, dig_sel = 1
- SHOW1: seg_n = ~DEC(disp[7:4]), dig_sel = 1
- BLANK1: seg_n = 7'h7F, dig_sel = 0
REQ-021 dig_sel SHALL change only while seg_n = 7'h7F (blank), which prevents ghosting.
REQ-022 frame_tick SHALL be registered and SHALL be high for the one cycle in which seg_n first shows the SHOW0 pattern.
REQ-023 DEC (active-high gfedcba) SHALL map 0..F to:
- 0..7: 3F 06 5B 4F 66 6D 7D 07
- 8..F: 7F 6F 77 7C 39 5E 79 71
REQ-024 The width of the phase counter SHALL be $clog2(max(REFRESH_DIV, BLANK_CYCLES)); the counter wraps only by the clear in REQ-016.

Reset
REQ-025 While rst = 1, the block SHALL hold state = BLANK1, phase counter = 0, disp = 8'h00, shadow = 8'h00, pending = 0, seg_n = 7'h7F, dig_sel = 0, frame_tick = 0.
REQ-026 After release, the first SHOW0 SHALL begin BLANK_CYCLES cycles later; that commit finds pending = 0, so the display shows "00".
REQ-027 A reset asserted mid-operation SHALL discard any pending value and return to the REQ-025 state on the next edge.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the 16-entry DEC table constant, and SEG_OFF = 7'h7F.
REQ-029 The sub-module hex_to_seg (4-bit input, 7-bit active-high output, purely combinational) SHALL be instantiated once; its input is muxed from disp by state.
REQ-030 Estimated RTL size: about 150-250 lines, including hex_to_seg.

Verification (REFRESH_DIV = 4, BLANK_CYCLES = 2, frame period = 12)
REQ-031 Release reset, no stimulus -> seg_n = 7F for 2 cycles, then ~3F for 4 cycles (dig_sel = 0), 7F for 2, ~3F for 4 (dig_sel = 1); frame_tick high exactly every 12 cycles.
REQ-032 Transfer 8'hA5 mid-SHOW1 -> value_ready low on the next cycle; the following SHOW0 shows ~6D (5) and SHOW1 shows ~77 (A); value_ready returns high the cycle after BLANK1->SHOW0.
REQ-033 Transfer 8'h12, then hold value_valid high with 8'h34 throughout -> 8'h34 is not accepted until the 8'h12 commit; a frame shows 12, then the next frame shows 34, with no mixed digits.
REQ-034 Sweep values 8'h00..8'hFF, one per frame -> every seg_n matches ~DEC for both digits; dig_sel never toggles while seg_n != 7F.
REQ-035 Assert rst for 1 cycle in SHOW1 while pending = 1 -> next cycle seg_n = 7F, dig_sel = 0, value_ready = 1; the display then shows 00 and the pending value is lost.
REQ-036 Hold value_valid low and change value_in every cycle -> disp never changes.
